// File: rtl/ram_writer_ctrl_if.sv
// Valid/ready stream bundle shared by the upstream and writer-side ports.
interface ram_writer_ctrl_if #(
    parameter int TDATA_WIDTH = 64
) ();
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/ram_writer_ctrl.sv
// Run-control wrapper for a ring-buffer RAM writer: arms/starts on enable or trigger,
// gates the stream, extends the writer pointer to a total word count and flags overruns.
module ram_writer_ctrl #(
    parameter int ADDR_WIDTH       = 20,
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int AXIS_TDATA_WIDTH = 64,
    parameter int CNT_WIDTH        = 64,
    parameter int DRAIN_CYCLES     = 16
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0] cfg_base,
    input  logic                      cfg_enable,
    input  logic                      cfg_trig_mode,
    input  logic [CNT_WIDTH-1:0]      cfg_rd_ptr,
    input  logic                      trig,
    input  logic [ADDR_WIDTH-1:0]     wr_sts,
    output logic                      wr_aresetn,
    output logic [AXI_ADDR_WIDTH-1:0] wr_cfg_data,
    ram_writer_ctrl_if.slave          s_axis,
    ram_writer_ctrl_if.master         m_axis,
    output logic [1:0]                sts_state,
    output logic [CNT_WIDTH-1:0]      sts_wr_count,
    output logic                      sts_overflow
);
    localparam int WRAP_WIDTH = CNT_WIDTH - ADDR_WIDTH;
    localparam int DRAIN_CW   = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic                      r_trig;
    logic [ADDR_WIDTH-1:0]     r_wr_sts;
    logic [DRAIN_CW-1:0]       r_drain_cnt;
    logic [WRAP_WIDTH-1:0]     r_wrap;
    logic                      r_overflow;
    logic [AXI_ADDR_WIDTH-1:0] r_cfg_data;

    logic                      w_active;
    logic                      w_sts_changed;
    logic                      w_drain_done;
    logic                      w_wrap_inc;
    logic                      w_idle_exit;
    logic                      w_gate_open;
    logic                      w_fill_over;
    logic [CNT_WIDTH-1:0]      w_wr_count;
    logic [CNT_WIDTH-1:0]      w_fill;

    assign w_active      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_sts_changed = (wr_sts != r_wr_sts);
    assign w_drain_done  = !w_sts_changed && (r_drain_cnt == DRAIN_CW'(DRAIN_CYCLES - 1));
    assign w_wrap_inc    = w_active && r_wr_sts[ADDR_WIDTH-1] && !wr_sts[ADDR_WIDTH-1];
    assign w_idle_exit   = (r_state == ST_IDLE) && (w_next_state != ST_IDLE);

    // Fill beyond one ring's worth means the writer lapped the consumer.
    assign w_wr_count    = {r_wrap, wr_sts};
    assign w_fill        = w_wr_count - cfg_rd_ptr;
    assign w_fill_over   = |w_fill[CNT_WIDTH-1:ADDR_WIDTH];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cfg_enable) w_next_state = cfg_trig_mode ? ST_ARMED : ST_RUN;
            end
            ST_ARMED: begin
                if (!cfg_enable)          w_next_state = ST_IDLE;
                else if (trig && !r_trig) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (!cfg_enable) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_drain_done) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments with reset sampled on the clock edge only.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_trig      <= 1'b0;
            r_wr_sts    <= '0;
            r_drain_cnt <= '0;
            r_wrap      <= '0;
            r_overflow  <= 1'b0;
            r_cfg_data  <= '0;
        end else begin
            r_state  <= w_next_state;
            r_trig   <= trig;
            r_wr_sts <= wr_sts;

            if ((r_state != ST_DRAIN) || w_sts_changed) r_drain_cnt <= '0;
            else                                        r_drain_cnt <= r_drain_cnt + 1'b1;

            if (w_idle_exit) begin
                r_cfg_data <= cfg_base;
                r_wrap     <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_wrap_inc)              r_wrap     <= r_wrap + 1'b1;
                if (w_active && w_fill_over) r_overflow <= 1'b1;
            end
        end
    end

    assign w_gate_open   = (r_state == ST_RUN);
    assign m_axis.tvalid = w_gate_open && s_axis.tvalid;
    assign s_axis.tready = w_gate_open && m_axis.tready;
    assign m_axis.tdata  = s_axis.tdata;

    assign wr_aresetn    = (r_state != ST_IDLE);
    assign wr_cfg_data   = r_cfg_data;
    assign sts_state     = r_state;
    assign sts_wr_count  = w_wr_count;
    assign sts_overflow  = r_overflow;
endmodule

// File: tb/tb_ram_writer_ctrl.sv
// Directed plus randomized bench for ram_writer_ctrl with a small ring (16 words)
// so wrap, overflow and drain timing are all reachable.
module tb_ram_writer_ctrl;
    localparam int AW = 4;
    localparam int CW = 12;
    localparam int XW = 32;
    localparam int DW = 64;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [XW-1:0] cfg_base;
    logic          cfg_enable;
    logic          cfg_trig_mode;
    logic [CW-1:0] cfg_rd_ptr;
    logic          trig;
    logic [AW-1:0] wr_sts;
    logic          wr_aresetn;
    logic [XW-1:0] wr_cfg_data;
    logic [1:0]    sts_state;
    logic [CW-1:0] sts_wr_count;
    logic          sts_overflow;

    ram_writer_ctrl_if #(.TDATA_WIDTH(DW)) s_if ();
    ram_writer_ctrl_if #(.TDATA_WIDTH(DW)) m_if ();

    ram_writer_ctrl #(
        .ADDR_WIDTH(AW), .AXI_ADDR_WIDTH(XW), .AXIS_TDATA_WIDTH(DW),
        .CNT_WIDTH(CW), .DRAIN_CYCLES(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_base(cfg_base), .cfg_enable(cfg_enable),
        .cfg_trig_mode(cfg_trig_mode), .cfg_rd_ptr(cfg_rd_ptr), .trig(trig),
        .wr_sts(wr_sts), .wr_aresetn(wr_aresetn), .wr_cfg_data(wr_cfg_data),
        .s_axis(s_if.slave), .m_axis(m_if.master), .sts_state(sts_state),
        .sts_wr_count(sts_wr_count), .sts_overflow(sts_overflow)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_random_stream();
        s_if.tdata  = {$urandom, $urandom};
        s_if.tvalid = 1'($urandom_range(0, 1));
        m_if.tready = 1'($urandom_range(0, 1));
    endtask

    task automatic check_gate_open(input string tag);
        check({tag, "_tvalid"}, 64'(m_if.tvalid), 64'(s_if.tvalid));
        check({tag, "_tready"}, 64'(s_if.tready), 64'(m_if.tready));
        check({tag, "_tdata"},  64'(m_if.tdata),  64'(s_if.tdata));
    endtask

    // Reference: total words written by the simulated writer and the overrun it implies.
    int unsigned exp_count;
    bit          hold_ok;

    initial begin
        aresetn       = 1'b0;
        cfg_base      = '0;
        cfg_enable    = 1'b0;
        cfg_trig_mode = 1'b0;
        cfg_rd_ptr    = '0;
        trig          = 1'b0;
        wr_sts        = '0;
        s_if.tdata    = 64'hDEAD_BEEF_0123_4567;
        s_if.tvalid   = 1'b1;
        m_if.tready   = 1'b1;
        repeat (3) tick();

        check("rst_state",    64'(sts_state),    64'd0);
        check("rst_wr_arstn", 64'(wr_aresetn),   64'd0);
        check("rst_tready",   64'(s_if.tready),  64'd0);
        check("rst_tvalid",   64'(m_if.tvalid),  64'd0);
        check("rst_tdata",    64'(m_if.tdata),   64'hDEAD_BEEF_0123_4567);
        check("rst_cfg_data", 64'(wr_cfg_data),  64'd0);
        check("rst_ovf",      64'(sts_overflow), 64'd0);
        check("rst_count",    64'(sts_wr_count), 64'd0);

        // Mode 0: start straight into RUN on enable.
        aresetn  = 1'b1;
        cfg_base = 32'h1000_0000;
        tick();
        check("idle_hold", 64'(sts_state), 64'd0);
        cfg_enable = 1'b1;
        tick();
        check("m0_state",    64'(sts_state),   64'd2);
        check("m0_cfg_data", 64'(wr_cfg_data), 64'h1000_0000);
        check("m0_wr_arstn", 64'(wr_aresetn),  64'd1);
        m_if.tready = 1'b0;
        #1 check("m0_tready_lo", 64'(s_if.tready), 64'd0);
        m_if.tready = 1'b1;
        #1 check("m0_tready_hi", 64'(s_if.tready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            drive_random_stream();
            #1 check_gate_open("m0_gate");
            tick();
        end
        cfg_base = 32'h3000_0000;
        tick();
        check("base_locked", 64'(wr_cfg_data), 64'h1000_0000);

        // Writer pointer steps 0..15,0,1: one wrap, count 17, overrun one cycle after 16.
        for (int v = 0; v < 18; v++) begin
            wr_sts = AW'(v % 16);
            tick();
            if (v == 15) begin
                check("wrap_cnt15", 64'(sts_wr_count), 64'd15);
                check("wrap_ovf15", 64'(sts_overflow), 64'd0);
            end
            if (v == 16) begin
                check("wrap_cnt16", 64'(sts_wr_count), 64'd16);
                check("ovf_not_yet", 64'(sts_overflow), 64'd0);
            end
        end
        check("wrap_cnt17", 64'(sts_wr_count), 64'd17);
        check("wrap_ctr",   64'(sts_wr_count[CW-1:AW]), 64'd1);
        check("ovf_set",    64'(sts_overflow), 64'd1);

        // Drain with a static pointer: back to IDLE on the 16th stable cycle.
        s_if.tvalid = 1'b1;
        m_if.tready = 1'b1;
        cfg_enable  = 1'b0;
        tick();
        check("drain_state",  64'(sts_state),   64'd3);
        check("drain_tvalid", 64'(m_if.tvalid), 64'd0);
        check("drain_tready", 64'(s_if.tready), 64'd0);
        check("drain_wr_arstn", 64'(wr_aresetn), 64'd1);
        hold_ok = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            hold_ok &= (sts_state == 2'd3);
        end
        check("drain_hold", 64'(hold_ok), 64'd1);
        tick();
        check("drain_idle",     64'(sts_state),    64'd0);
        check("drain_wr_arstn0", 64'(wr_aresetn),  64'd0);
        check("ovf_sticky",     64'(sts_overflow), 64'd1);

        // Trigger mode: a trigger already high must not start; only a fresh rising edge does.
        cfg_base      = 32'h2000_0040;
        trig          = 1'b1;
        cfg_trig_mode = 1'b1;
        cfg_enable    = 1'b1;
        tick();
        check("armed_state",    64'(sts_state),    64'd1);
        check("armed_ovf_clr",  64'(sts_overflow), 64'd0);
        check("armed_wrap_clr", 64'(sts_wr_count), 64'd1);
        check("armed_cfg_data", 64'(wr_cfg_data),  64'h2000_0040);
        check("armed_wr_arstn", 64'(wr_aresetn),   64'd1);
        check("armed_tvalid",   64'(m_if.tvalid),  64'd0);
        check("armed_tready",   64'(s_if.tready),  64'd0);
        hold_ok = 1'b1;
        repeat (3) begin
            tick();
            hold_ok &= (sts_state == 2'd1);
        end
        check("armed_no_edge", 64'(hold_ok), 64'd1);
        trig = 1'b0;
        tick();
        check("armed_trig_lo", 64'(sts_state), 64'd1);
        trig = 1'b1;
        tick();
        check("trig_run", 64'(sts_state), 64'd2);
        hold_ok = 1'b1;
        repeat (2) begin
            tick();
            hold_ok &= (sts_state == 2'd2);
        end
        check("trig_single_entry", 64'(hold_ok), 64'd1);
        trig = 1'b0;

        // Randomized run: writer advances 1..3 words per step, consumer parked at 0.
        exp_count = 1;
        for (int i = 0; i < 24; i++) begin
            exp_count += $urandom_range(1, 3);
            wr_sts = AW'(exp_count % 16);
            drive_random_stream();
            #1 check_gate_open("rnd_gate");
            tick();
            tick();
            check("rnd_count", 64'(sts_wr_count), 64'(exp_count % (1 << CW)));
            check("rnd_ovf",   64'(sts_overflow), 64'(exp_count >= 16));
        end

        // Drain with a pointer move at cycle 10 and a re-enable glitch that must be ignored.
        cfg_enable = 1'b0;
        tick();
        check("drain2_state", 64'(sts_state), 64'd3);
        hold_ok = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            tick();
            hold_ok &= (sts_state == 2'd3);
            if (k == 3)  cfg_enable = 1'b1;
            if (k == 6)  cfg_enable = 1'b0;
            if (k == 10) wr_sts = wr_sts + 1'b1;
        end
        check("drain2_restart", 64'(hold_ok), 64'd1);
        tick();
        check("drain2_idle", 64'(sts_state), 64'd0);

        // Disable wins over a simultaneous trigger edge in ARMED.
        cfg_trig_mode = 1'b1;
        cfg_enable    = 1'b1;
        tick();
        check("prio_armed", 64'(sts_state), 64'd1);
        cfg_enable = 1'b0;
        trig       = 1'b1;
        tick();
        check("prio_idle", 64'(sts_state), 64'd0);
        trig = 1'b0;

        // Reset in the middle of a run closes everything on the first reset edge.
        cfg_trig_mode = 1'b0;
        cfg_enable    = 1'b1;
        tick();
        check("mrst_run", 64'(sts_state), 64'd2);
        s_if.tvalid = 1'b1;
        m_if.tready = 1'b1;
        #1 check("mrst_open", 64'(m_if.tvalid), 64'd1);
        aresetn    = 1'b0;
        cfg_enable = 1'b0;
        tick();
        check("mrst_state",    64'(sts_state),    64'd0);
        check("mrst_wr_arstn", 64'(wr_aresetn),   64'd0);
        check("mrst_tready",   64'(s_if.tready),  64'd0);
        check("mrst_tvalid",   64'(m_if.tvalid),  64'd0);
        check("mrst_cfg_data", 64'(wr_cfg_data),  64'd0);
        check("mrst_ovf",      64'(sts_overflow), 64'd0);
        check("mrst_wrap",     64'(sts_wr_count[CW-1:AW]), 64'd0);
        aresetn = 1'b1;
        tick();
        check("post_rst_idle", 64'(sts_state), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_writer_ctrl.md
RAM_WRITER_CTRL -- requirements
Module: ram_writer_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, writer word-address width; ring buffer size is 2^ADDR_WIDTH words.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter AXIS_TDATA_WIDTH, default 64, stream data width.
REQ-004 SHALL have parameter CNT_WIDTH, default 64, total-word-count width (> ADDR_WIDTH).
REQ-005 SHALL have parameter DRAIN_CYCLES, default 16, idle cycles that end DRAIN.
REQ-006 SHALL have ports:
- aclk  in  1  single clock, all logic on rising edge.
- aresetn  in  1  synchronous, active-low reset.
- cfg_base  in  AXI_ADDR_WIDTH  buffer base byte address.
- cfg_enable  in  1  run request, level.
- cfg_trig_mode  in  1  0 = start on enable, 1 = wait for trigger.
- cfg_rd_ptr  in  CNT_WIDTH  consumer total-word count from software.
- trig  in  1  external trigger, synchronous to aclk.
- wr_sts  in  ADDR_WIDTH  writer word pointer (writer sts_data).
- wr_aresetn  out  1  writer reset, active-low.
- wr_cfg_data  out  AXI_ADDR_WIDTH  writer base address.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  upstream data.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  upstream ready.
- m_axis_tdata  out  AXIS_TDATA_WIDTH  to writer.
- m_axis_tvalid  out  1  to writer.
- m_axis_tready  in  1  from writer.
- sts_state  out  2  current state encoding.
- sts_wr_count  out  CNT_WIDTH  total words written since start.
- sts_overflow  out  1  sticky overrun flag.

Function
REQ-007 SHALL implement FSM IDLE=0, ARMED=1, RUN=2, DRAIN=3; sts_state = state register.
REQ-008 IDLE: wr_aresetn=0; gate closed; cfg_enable=1 -> RUN if cfg_trig_mode=0, else ARMED.
REQ-009 ARMED: wr_aresetn=1; gate closed; trig rising edge (trig=1, registered trig=0) -> RUN; cfg_enable=0 -> IDLE, with priority over trig.
REQ-010 RUN: wr_aresetn=1; gate open; cfg_enable=0 -> DRAIN.
REQ-011 DRAIN: wr_aresetn=1; gate closed; -> IDLE once wr_sts unchanged for DRAIN_CYCLES consecutive cycles; cfg_enable re-asserted is ignored until IDLE.
REQ-012 Gate open: m_axis_tvalid = s_axis_tvalid, s_axis_tready = m_axis_tready, combinational, zero latency. Gate closed: both 0.
REQ-013 m_axis_tdata SHALL equal s_axis_tdata at all times.
REQ-014 wr_cfg_data SHALL latch cfg_base on every IDLE exit; cfg_base changes outside IDLE have no effect.
REQ-015 On IDLE exit, the wrap counter and sts_overflow SHALL clear in the same cycle, and the clear has priority over any increment.
REQ-016 Wrap counter, CNT_WIDTH-ADDR_WIDTH bits: +1 in RUN/DRAIN when registered wr_sts MSB=1 and current wr_sts MSB=0; wraps modulo 2^(CNT_WIDTH-ADDR_WIDTH).
REQ-017 sts_wr_count SHALL equal {wrap counter, wr_sts}, combinational.
REQ-018 Fill = sts_wr_count - cfg_rd_ptr, modulo 2^CNT_WIDTH; in RUN/DRAIN, fill >= 2^ADDR_WIDTH SHALL set sts_overflow one cycle later; it stays set until the next IDLE exit.
REQ-019 Overflow SHALL NOT stop or gate the stream.
REQ-020 The DRAIN stability counter SHALL reset on any wr_sts change and on DRAIN entry.

Reset
REQ-021 aresetn=0 at a clock edge, in any state: state=IDLE, wr_cfg_data=0, wrap counter=0, sts_overflow=0, registered trig=0, registered wr_sts=0, drain counter=0.
REQ-022 During and after reset: wr_aresetn=0, s_axis_tready=0, m_axis_tvalid=0, sts_state=0.
REQ-023 Reset in RUN SHALL close the gate on the first reset edge; data in the writer's FIFO is the writer's responsibility.

Verification
REQ-024 Mode 0 start: cfg_base=0x1000_0000, cfg_enable 0->1 -> next cycle state=RUN, wr_cfg_data=0x1000_0000, wr_aresetn=1, s_axis_tready follows m_axis_tready.
REQ-025 Trigger: cfg_trig_mode=1 -> state ARMED with gate closed; trig held 1 for 3 cycles -> exactly one RUN entry, one cycle after the rising edge.
REQ-026 Wrap: ADDR_WIDTH=4, wr_sts stepped 0..15,0,1 in RUN -> sts_wr_count=17, wrap counter=1.
REQ-027 Overflow: ADDR_WIDTH=4, cfg_rd_ptr=0, sts_wr_count reaches 16 -> sts_overflow=1 next cycle; restart from IDLE -> sts_overflow=0.
REQ-028 Drain: cfg_enable 1->0 in RUN -> gate closed immediately; wr_sts static -> IDLE after 16 cycles, wr_aresetn=0; a wr_sts change at cycle 10 restarts the count.
REQ-029 Mid-run reset: aresetn=0 for 1 cycle in RUN with s_axis_tvalid=1 -> next cycle state=IDLE, all outputs at reset values.
